gate_bist: RTL and testbench

Synthesizable built-in self-test engine for 2-input logic gates such as nor_gate. It is the hardware counterpart of the gate stimulus benches: it drives A/B onto the gate under test and reads back Y. It then checks Y against a parameterised truth table and reports the error count, which vectors failed, and pass/fail. It sits beside any basics-library gate instance as an on-chip checker.

---
 rtl/gate_bist_pkg.sv | 19 +
 rtl/gate_bist.sv | 93 +++++++++
 tb/tb_gate_bist.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared state encoding, vector constants and truth tables for gate_bist
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;

    // Bit i is the expected Y for input vector {A,B} == i.
    localparam logic [3:0] NOR_TRUTH = 4'b0001;
    localparam logic [3:0] OR_TRUTH  = 4'b1110;
    localparam logic [3:0] AND_TRUTH = 4'b1000;

endpackage

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - self-test engine sweeping all {A,B} vectors through a 2-input gate and checking Y
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] TRUTH         = NOR_TRUTH,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter int         ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_e           state;
    logic [VEC_W-1:0] vec;
    logic [7:0]       pass_cnt;
    logic [3:0]       settle_cnt;

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        vec        <= '0;
                        pass_cnt   <= '0;
                        settle_cnt <= '0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (y_in != TRUTH[vec]) begin
                        fail_vec[vec] <= 1'b1;
                        if (err_count != ERR_MAX)
                            err_count <= err_count + ERR_W'(1);
                    end
                    if (vec == LAST_VEC && pass_cnt == PASS_LAST) begin
                        state <= DONE;
                        a_out <= 1'b0;
                        b_out <= 1'b0;
                    end else begin
                        // vec wraps 3->0 naturally; the wrap marks the end of a sweep
                        state          <= DRIVE;
                        vec            <= vec + VEC_W'(1);
                        {a_out, b_out} <= vec + VEC_W'(1);
                        if (vec == LAST_VEC)
                            pass_cnt <= pass_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - randomized and directed self-checking bench for gate_bist
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [2:0] start_v;
    logic [2:0] yr;
    logic [2:0] y_v;
    int         mode_v [3];

    logic [2:0]      a_v, b_v, busy_v, done_v, pass_v;
    logic [2:0][3:0] fail_v;
    logic [7:0]      err_a, err_b;
    logic [1:0]      err_c;

    int checks   = 0;
    int failures = 0;

    // mode 0: NOR gate, mode 1: OR gate, otherwise the bench-driven level yr
    function automatic logic gy(input int mode, input logic a, input logic b, input logic r);
        if (mode == 0) return ~(a | b);
        if (mode == 1) return a | b;
        return r;
    endfunction

    assign y_v[0] = gy(mode_v[0], a_v[0], b_v[0], yr[0]);
    assign y_v[1] = gy(mode_v[1], a_v[1], b_v[1], yr[1]);
    assign y_v[2] = gy(mode_v[2], a_v[2], b_v[2], yr[2]);

    gate_bist u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .y_in(y_v[0]),
        .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_a), .fail_vec(fail_v[0])
    );

    gate_bist #(.PASSES(3)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .y_in(y_v[1]),
        .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_b), .fail_vec(fail_v[1])
    );

    gate_bist #(.PASSES(2), .ERR_W(2)) u_c (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .y_in(y_v[2]),
        .a_out(a_v[2]), .b_out(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_c), .fail_vec(fail_v[2])
    );

    function automatic int get_err(input int idx);
        if (idx == 0) return int'(err_a);
        if (idx == 1) return int'(err_b);
        return int'(err_c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int idx, input string tag);
        check({tag, "_busy"}, int'(busy_v[idx]), 0);
        check({tag, "_done"}, int'(done_v[idx]), 0);
        check({tag, "_pass"}, int'(pass_v[idx]), 0);
        check({tag, "_ab"}, int'({a_v[idx], b_v[idx]}), 0);
        check({tag, "_err"}, get_err(idx), 0);
        check({tag, "_fail"}, int'(fail_v[idx]), 0);
    endtask

    // One run with SETTLE_CYCLES=2: every vector occupies 3 cycles, the third one being the compare.
    task automatic run(input int idx, input int mode, input logic stuck, input int np,
                       input int errmax, input int restart_k,
                       output int e, output logic [3:0] f);
        int n;
        int vec;
        logic yv;
        n = 1 + 4 * np * 3;
        e = 0;
        f = 4'b0000;
        mode_v[idx] = mode;
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k < n) begin
                vec = ((k - 1) / 3) % 4;
                start_v[idx] = (k == restart_k);
                if (k == 1) begin
                    check("first_err_clear", get_err(idx), 0);
                    check("first_fail_clear", int'(fail_v[idx]), 0);
                end
                check("busy", int'(busy_v[idx]), 1);
                check("done_low", int'(done_v[idx]), 0);
                check("ab_vec", int'({a_v[idx], b_v[idx]}), vec);
                yr[idx] = (mode == 2) ? stuck : 1'($urandom);
                if ((k - 1) % 3 == 2) begin
                    yv = (mode == 0) ? ~(vec[1] | vec[0]) :
                         (mode == 1) ?  (vec[1] | vec[0]) : yr[idx];
                    // the gate is expected to behave as NOR
                    if (yv != (vec == 0)) begin
                        if (e < errmax) e++;
                        f[vec] = 1'b1;
                    end
                end
                tick();
            end else begin
                check("done_high", int'(done_v[idx]), 1);
                check("busy_end", int'(busy_v[idx]), 0);
                check("ab_end", int'({a_v[idx], b_v[idx]}), 0);
                check("err_end", get_err(idx), e);
                check("fail_end", int'(fail_v[idx]), int'(f));
                check("pass_end", int'(pass_v[idx]), (e == 0) ? 1 : 0);
            end
        end
        start_v[idx] = 1'b0;
    endtask

    initial begin
        int e;
        logic [3:0] f;
        rst_v = 3'b111;
        start_v = 3'b000;
        yr = 3'b000;
        for (int i = 0; i < 3; i++) mode_v[i] = 2;
        tick();
        tick();
        rst_v = 3'b000;
        check_reset(0, "rst_a");
        check_reset(1, "rst_b");
        check_reset(2, "rst_c");

        // y_in is ignored outside SAMPLE
        yr = 3'b111;
        tick();
        tick();
        check_reset(0, "idle_a");

        run(0, 0, 1'b0, 1, 255, 0, e, f);
        check("nor_pass", int'(pass_v[0]), 1);

        run(0, 1, 1'b0, 1, 255, 5, e, f);
        check("or_err", get_err(0), 4);
        check("or_fail", int'(fail_v[0]), 4'b1111);

        // restarted straight from DONE
        run(0, 0, 1'b0, 1, 255, 0, e, f);
        check("rerun_pass", int'(pass_v[0]), 1);

        for (int r = 0; r < 6; r++) run(0, 3, 1'b0, 1, 255, 0, e, f);

        // reset during the compare cycle of vector 2
        mode_v[0] = 1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        check("pre_rst_busy", int'(busy_v[0]), 1);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        check_reset(0, "midrst");
        tick();
        run(0, 0, 1'b0, 1, 255, 0, e, f);

        run(1, 2, 1'b1, 3, 255, 0, e, f);
        check("stuck1_err", get_err(1), 9);
        check("stuck1_fail", int'(fail_v[1]), 4'b1110);
        run(1, 3, 1'b0, 3, 255, 0, e, f);

        run(2, 1, 1'b0, 2, 3, 0, e, f);
        check("sat_err", get_err(2), 3);
        check("sat_fail", int'(fail_v[2]), 4'b1111);
        run(2, 3, 1'b0, 2, 3, 0, e, f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
